div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Shares one iterative signed divider (`div` instance, DIVIDEND_WIDTH = DIVISOR_WIDTH = DATA_SIZE) among NUM_REQ datapath requesters.
- Requesters are, for example, the Hough/normalisation stages.
- Grants round-robin, latches operands, sequences a single divide, and returns quotient/remainder/overflow to the winner over a valid/ready response handshake.
- Only one division is outstanding at any time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_SIZE, DATA_SIZE from globals.sv, operand/result width.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request strobe; held until accepted.
- req_ready  out  NUM_REQ  one-hot accept.
- req_dividend  in  NUM_REQ*DATA_SIZE  packed signed dividends; slice i belongs to requester i.
- req_divisor  in  NUM_REQ*DATA_SIZE  packed signed divisors.
- resp_valid  out  NUM_REQ  one-hot result valid.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_quotient  out  DATA_SIZE  shared signed quotient bus.
- resp_remainder  out  DATA_SIZE  shared signed remainder bus.
- resp_overflow  out  1  divider overflow (includes divide-by-zero).
- div_valid_in  out  1  start pulse to divider.
- div_dividend  out  DATA_SIZE  operand to divider.
- div_divisor  out  DATA_SIZE  operand to divider.
- div_quotient  in  DATA_SIZE  divider result.
- div_remainder  in  DATA_SIZE  divider result.
- div_overflow  in  1  divider overflow.
- div_valid_out  in  1  divider result strobe.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (reset=0, async):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0; operand and result registers 0.
- IDLE:
  - Winner = first set req_valid bit searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 is combinational from registered state and req_valid; it is never asserted outside IDLE.
  - On handshake: latch the winner's dividend/divisor and grant index g, then go to ISSUE.
  - No req_valid set: stay in IDLE.
- ISSUE:
  - div_valid_in=1 for exactly one cycle.
  - div_dividend/div_divisor driven from latched registers; they hold those values through WAIT.
  - Next state WAIT.
- WAIT:
  - Hold until div_valid_out=1.
  - Then register quotient, remainder and overflow, and go to RESP.
  - div_valid_out in any other state is ignored.
- RESP:
  - resp_valid[g]=1, with result buses stable until resp_ready[g]=1.
  - On resp_valid[g] & resp_ready[g]: last_grant=g, go to IDLE.
  - resp_ready of other requesters is ignored.
- Latency: accept at cycle T, div_valid_in at T+1; divider result at T+1+L gives resp_valid at T+2+L. Minimum request-to-request gap is L+3 cycles.
- Requester i may hold req_valid while its own response is pending; it is not re-granted until after RESP completes.
- Divisor 0 is passed through unchanged; the divider's overflow is returned verbatim.
- Operand and result values pass through unmodified; no width change or sign handling occurs in the arbiter.
- Simultaneous requests: strict round-robin; a continuously requesting set is served i, i+1, ... with no starvation.
- Reset asserted mid-operation: immediate return to IDLE. Any in-flight divider result is discarded, since it arrives in IDLE and is ignored.

Optional Feature:
- Macro DIV_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without div_valid_out, go to RESP with quotient=0, remainder=0, resp_overflow=1, and pulse output timeout_err for 1 cycle. The timeout_err port exists only when the macro is defined.
  - A late div_valid_out arriving afterwards is ignored.
- Undefined: no counter and no port; WAIT waits indefinitely.

Test Plan:
- Single request: req 0 with dividend=-9170000, divisor=10 → quotient=-917000, remainder=0, overflow=0. resp_valid[0] arrives L+2 cycles after accept.
- Fairness: all 4 req_valid held for 8 divisions, each 100/7 → grant order 0,1,2,3,0,1,2,3; every result is 14 r 2.
- Divide-by-zero: req 2 with 5/0 → resp_overflow=1, resp_valid[2] only.
- Response backpressure: resp_ready[1] held low 20 cycles → resp buses stable, req_ready all 0, busy=1; release → IDLE next cycle.
- Reset in WAIT: reset pulsed low mid-divide → all outputs 0 and next grant goes to req 0. A stale div_valid_out produces no resp_valid.
- With DIV_ARB_TIMEOUT_EN and the divider stub never responding: after 64 WAIT cycles, timeout_err pulses once and resp_overflow=1.

Source files
------------

// File: rtl/div_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_arbiter_if
//
// Purpose:
//   Bundles the requester-side request/response buses and the divider-side
//   operand/result buses of the divider arbiter into one interface.
//
// Parameters:
//   NUM_REQ    number of requesters sharing the divider (2..8)
//   DATA_SIZE  operand / result width
//
// Signals:
//   req_valid / req_ready          per-requester request handshake
//   req_dividend / req_divisor     packed operands, slice i = requester i
//   resp_valid / resp_ready        per-requester response handshake
//   resp_quotient / resp_remainder shared result buses
//   resp_overflow                  divider overflow (includes divide-by-zero)
//   div_valid_in                   one-cycle start pulse to the divider
//   div_dividend / div_divisor     operands to the divider
//   div_quotient / div_remainder   divider results
//   div_overflow / div_valid_out   divider overflow flag and result strobe
//
// Modports:
//   master  the arbiter's view (drives ready/response/divider-start signals)
//   slave   the environment's view (requesters plus the divider)
//
// Handshake semantics (all valid/ready pairs in this interface):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Once valid is raised, the source holds valid and its payload steady
//   until that transfer edge; valid never depends combinationally on ready.
//   The divider strobes (div_valid_in, div_valid_out) are single-cycle pulses
//   with no back-pressure.
// -----------------------------------------------------------------------------
interface div_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*DATA_SIZE-1:0] req_dividend;
    logic [NUM_REQ*DATA_SIZE-1:0] req_divisor;

    logic [NUM_REQ-1:0]           resp_valid;
    logic [NUM_REQ-1:0]           resp_ready;
    logic [DATA_SIZE-1:0]         resp_quotient;
    logic [DATA_SIZE-1:0]         resp_remainder;
    logic                         resp_overflow;

    logic                         div_valid_in;
    logic [DATA_SIZE-1:0]         div_dividend;
    logic [DATA_SIZE-1:0]         div_divisor;
    logic [DATA_SIZE-1:0]         div_quotient;
    logic [DATA_SIZE-1:0]         div_remainder;
    logic                         div_overflow;
    logic                         div_valid_out;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_dividend,
        input  req_divisor,
        output resp_valid,
        input  resp_ready,
        output resp_quotient,
        output resp_remainder,
        output resp_overflow,
        output div_valid_in,
        output div_dividend,
        output div_divisor,
        input  div_quotient,
        input  div_remainder,
        input  div_overflow,
        input  div_valid_out
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_dividend,
        output req_divisor,
        input  resp_valid,
        output resp_ready,
        input  resp_quotient,
        input  resp_remainder,
        input  resp_overflow,
        input  div_valid_in,
        input  div_dividend,
        input  div_divisor,
        output div_quotient,
        output div_remainder,
        output div_overflow,
        output div_valid_out
    );
endinterface

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Purpose:
//   Shares one iterative signed divider among NUM_REQ requesters. A
//   round-robin pick selects one requester in IDLE, its operands are latched,
//   a single divide is started and awaited, and the result is returned to the
//   winner over a valid/ready response handshake. Exactly one division is in
//   flight at any time. Operands and results pass through untouched.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   DATA_SIZE       operand / result width
//   TIMEOUT_CYCLES  WAIT watchdog limit (only with DIV_ARB_TIMEOUT_EN)
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous active-low reset
//   bus            div_arbiter_if.master (request, response, divider buses)
//   o_busy         high in any state other than IDLE
//   o_state        current FSM state (debug visibility)
//   o_timeout_err  one-cycle pulse when the watchdog fires
//                  (port present only with DIV_ARB_TIMEOUT_EN)
//
// Optional feature:
//   `define DIV_ARB_TIMEOUT_EN to add the WAIT watchdog. Without it the FSM
//   waits in WAIT indefinitely for the divider.
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32
`ifdef DIV_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic            i_clk,
    input  logic            i_reset,
    div_arbiter_if.master   bus,
    output logic            o_busy,
    output logic [1:0]      o_state
`ifdef DIV_ARB_TIMEOUT_EN
    ,
    output logic            o_timeout_err
`endif
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    // Last requester whose response completed; the search starts just after it.
    logic [GW-1:0]        r_last_grant;
    // Requester owning the division currently in flight.
    logic [GW-1:0]        r_grant;

    logic [DATA_SIZE-1:0] r_dividend;
    logic [DATA_SIZE-1:0] r_divisor;
    logic [DATA_SIZE-1:0] r_quotient;
    logic [DATA_SIZE-1:0] r_remainder;
    logic                 r_overflow;

    logic                 w_found;
    logic [GW-1:0]        w_winner;
    logic [GW-1:0]        w_cand;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]        r_wait_cnt;
    logic                 r_timeout_err;
    logic                 w_timeout;
`endif

    // -------------------------------------------------------------------------
    // Round-robin search: first set req_valid bit at last_grant+1,
    // last_grant+2, ... modulo NUM_REQ. The last candidate examined is
    // last_grant itself, so a lone requester is always found.
    // -------------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and handshake outputs.
    // req_ready is offered only in IDLE; since the winner is picked from
    // req_valid, an offered ready always completes a request handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        bus.req_ready    = '0;
        bus.resp_valid   = '0;
        bus.div_valid_in = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        w_timeout        = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    bus.req_ready[w_winner] = 1'b1;
                    w_next                  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.div_valid_in = 1'b1;
                w_next           = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.div_valid_out) begin
                    w_next = ST_RESP;
                end
`ifdef DIV_ARB_TIMEOUT_EN
                // A real result in the same cycle takes precedence.
                else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                bus.resp_valid[r_grant] = 1'b1;
                if (bus.resp_ready[r_grant]) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Grant, operand and result registers.
    // div_valid_out outside WAIT is ignored, which also discards a result that
    // was in flight when reset pulled the FSM back to IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant      <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winner;
                        r_dividend <= bus.req_dividend[int'(w_winner)*DATA_SIZE +: DATA_SIZE];
                        r_divisor  <= bus.req_divisor[int'(w_winner)*DATA_SIZE +: DATA_SIZE];
                    end
                end
                ST_WAIT: begin
                    if (bus.div_valid_out) begin
                        r_quotient  <= bus.div_quotient;
                        r_remainder <= bus.div_remainder;
                        r_overflow  <= bus.div_overflow;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_overflow  <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.resp_ready[r_grant]) begin
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // WAIT watchdog. The counter is cleared in ISSUE so it reads 0 on the
    // first WAIT cycle; the error pulse lines up with the first RESP cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`endif

    // -------------------------------------------------------------------------
    // Output drive. Operands stay on the divider bus from ISSUE through WAIT
    // (and beyond) because they come straight from the latched registers.
    // -------------------------------------------------------------------------
    assign bus.div_dividend   = r_dividend;
    assign bus.div_divisor    = r_divisor;
    assign bus.resp_quotient  = r_quotient;
    assign bus.resp_remainder = r_remainder;
    assign bus.resp_overflow  = r_overflow;

    assign o_busy  = (r_state != ST_IDLE);
    assign o_state = r_state;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int NR  = 4;
    localparam int DS  = 32;
    localparam int LAT = 3;
    localparam int TO  = 64;

    // ------------------------------------------------------------------ clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus();

    logic       busy;
    logic [1:0] state;
`ifdef DIV_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    div_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DS)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus),
        .o_busy  (busy),
        .o_state (state)
`ifdef DIV_ARB_TIMEOUT_EN
        ,
        .o_timeout_err (timeout_err)
`endif
    );

    // ------------------------------------------------------------------ scoreboard
    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ divider stub
    // Fixed-latency divider: div_valid_out is sampled LAT edges after the edge
    // that sampled div_valid_in.
    bit                 stub_silent = 1'b0;
    int                 stub_cnt    = 0;
    logic signed [DS-1:0] stub_a;
    logic signed [DS-1:0] stub_b;

    initial begin
        bus.div_valid_out = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        bus.div_overflow  = 1'b0;
        stub_a = '0;
        stub_b = '0;
        forever begin
            @(negedge clk);
            bus.div_valid_out = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    bus.div_valid_out = 1'b1;
                    if (stub_b == 0 || (stub_a == {1'b1, {(DS-1){1'b0}}} && stub_b == -1)) begin
                        bus.div_quotient  = '0;
                        bus.div_remainder = '0;
                        bus.div_overflow  = 1'b1;
                    end else begin
                        bus.div_quotient  = stub_a / stub_b;
                        bus.div_remainder = stub_a % stub_b;
                        bus.div_overflow  = 1'b0;
                    end
                end
            end
            if (bus.div_valid_in && !stub_silent) begin
                stub_a   = bus.div_dividend;
                stub_b   = bus.div_divisor;
                stub_cnt = LAT;
            end
        end
    end

    // ------------------------------------------------------------------ driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output int gi);
        gi = -1;
        for (int t = 0; t < 200; t++) begin
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gi = i;
                break;
            end
            step();
        end
    endtask

    // Called on the first negedge after the accepting edge.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (bus.resp_valid == '0 && lat < 300) begin
            step();
            lat++;
        end
    endtask

    task automatic set_ops(input int idx, input logic [DS-1:0] a, input logic [DS-1:0] b);
        bus.req_dividend[idx*DS +: DS] = a;
        bus.req_divisor[idx*DS +: DS]  = b;
    endtask

    task automatic run_one(input string nm, input int idx, input logic [DS-1:0] a,
                           input logic [DS-1:0] b, input logic [DS-1:0] q,
                           input logic [DS-1:0] r, input logic ovf);
        int gi;
        int lat;
        set_ops(idx, a, b);
        bus.req_valid[idx] = 1'b1;
        #1;
        wait_grant(gi);
        check({nm, "_grant"}, bus.req_ready, 4'b1 << idx);
        step();
        bus.req_valid[idx] = 1'b0;
        wait_resp(lat);
        check({nm, "_latency"}, lat, LAT + 2);
        check({nm, "_resp_valid"}, bus.resp_valid, 4'b1 << idx);
        check({nm, "_quotient"}, bus.resp_quotient, q);
        check({nm, "_remainder"}, bus.resp_remainder, r);
        check({nm, "_overflow"}, bus.resp_overflow, ovf);
        bus.resp_ready[idx] = 1'b1;
        step();
        bus.resp_ready[idx] = 1'b0;
        check({nm, "_idle_after"}, {busy, bus.resp_valid}, 5'b0);
    endtask

    // ------------------------------------------------------------------ vectors
    typedef struct {
        string      nm;
        int         idx;
        logic [DS-1:0] a;
        logic [DS-1:0] b;
        logic [DS-1:0] q;
        logic [DS-1:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin : main
        int gi;
        int lat;
        int pulses;
        logic [1:0] e;

        vecs[0] = '{"single",   0, -9170000,       10,  -917000,  0, 1'b0};
        vecs[1] = '{"div0",     2, 5,              0,   0,        0, 1'b1};
        vecs[2] = '{"neg_num",  1, -7,             2,   -3,       -1, 1'b0};
        vecs[3] = '{"neg_den",  3, 7,              -2,  -3,       1, 1'b0};
        vecs[4] = '{"min_m1",   0, 32'h8000_0000,  -1,  0,        0, 1'b1};
        vecs[5] = '{"r3_100_7", 3, 100,            7,   14,       2, 1'b0};

        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.resp_ready   = '0;

        // ---------------- reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", state, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_handshake", {bus.req_ready, bus.resp_valid, bus.div_valid_in}, 9'b0);
        check("rst_results", {bus.resp_quotient, bus.resp_remainder}, 64'b0);
        check("rst_ops", {bus.div_dividend, bus.div_divisor}, 64'b0);
        check("rst_overflow", bus.resp_overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---------------- fairness: all four hold requests, 100/7 each
        for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % 4));
        for (int i = 0; i < NR; i++) set_ops(i, 100, 7);
        bus.req_valid = '1;
        #1;
        for (int n = 0; n < 8; n++) begin
            wait_grant(gi);
            e = exp_q.pop_front();
            check("rr_grant", bus.req_ready, 4'b1 << e);
            step();
            wait_resp(lat);
            check("rr_latency", lat, LAT + 2);
            check("rr_resp_valid", bus.resp_valid, 4'b1 << e);
            check("rr_result", {bus.resp_quotient, bus.resp_remainder}, {32'd14, 32'd2});
            check("rr_no_ready_in_resp", bus.req_ready, 4'b0);
            bus.resp_ready[e] = 1'b1;
            step();
            bus.resp_ready[e] = 1'b0;
        end
        bus.req_valid = '0;
        step();

        // ---------------- table-driven single requests
        for (int v = 0; v < 6; v++) begin
            run_one(vecs[v].nm, vecs[v].idx, vecs[v].a, vecs[v].b,
                    vecs[v].q, vecs[v].r, vecs[v].ovf);
        end

        // ---------------- response backpressure on requester 1
        set_ops(1, 20, 3);
        bus.req_valid[1] = 1'b1;
        #1;
        wait_grant(gi);
        check("bp_grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid[1] = 1'b0;
        wait_resp(lat);
        check("bp_latency", lat, LAT + 2);
        set_ops(0, 9, 3);
        bus.req_valid[0]  = 1'b1;
        bus.resp_ready[0] = 1'b1;   // not the owner: must be ignored
        for (int t = 0; t < 20; t++) begin
            step();
            check("bp_hold_ctrl", {bus.resp_valid, bus.req_ready, busy, state}, {4'b0010, 4'b0000, 1'b1, 2'd3});
            check("bp_hold_data", {bus.resp_quotient, bus.resp_remainder}, {32'd6, 32'd2});
        end
        bus.resp_ready[0] = 1'b0;
        bus.resp_ready[1] = 1'b1;
        step();
        bus.resp_ready[1] = 1'b0;
        check("bp_release_idle", {busy, state}, 3'b0);
        check("bp_next_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid[0] = 1'b0;
        wait_resp(lat);
        check("bp_req0_result", {bus.resp_valid, bus.resp_quotient, bus.resp_remainder}, {4'b0001, 32'd3, 32'd0});
        bus.resp_ready[0] = 1'b1;
        step();
        bus.resp_ready[0] = 1'b0;

        // ---------------- reset while the divider is working
        set_ops(2, 5, 1);
        bus.req_valid[2] = 1'b1;
        #1;
        wait_grant(gi);
        check("rw_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid[2] = 1'b0;
        step();
        check("rw_in_wait", state, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rw_rst_ctrl", {busy, state, bus.req_ready, bus.resp_valid, bus.div_valid_in}, 12'b0);
        check("rw_rst_ops", {bus.div_dividend, bus.div_divisor}, 64'b0);
        check("rw_rst_results", {bus.resp_quotient, bus.resp_remainder, 31'b0, bus.resp_overflow}, 96'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int t = 0; t < 6; t++) begin
            step();
            check("rw_stale_ignored", {busy, bus.resp_valid}, 5'b0);
        end
        for (int i = 0; i < NR; i++) set_ops(i, 5, 1);
        bus.req_valid = '1;
        #1;
        check("rw_first_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        wait_resp(lat);
        check("rw_result", {bus.resp_valid, bus.resp_quotient, bus.resp_remainder}, {4'b0001, 32'd5, 32'd0});
        bus.resp_ready[0] = 1'b1;
        step();
        bus.resp_ready[0] = 1'b0;

`ifdef DIV_ARB_TIMEOUT_EN
        // ---------------- watchdog with a silent divider
        stub_silent = 1'b1;
        set_ops(0, 1, 1);
        bus.req_valid[0] = 1'b1;
        #1;
        wait_grant(gi);
        check("to_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid[0] = 1'b0;
        pulses = 0;
        lat = 1;
        while (bus.resp_valid == '0 && lat < 300) begin
            if (timeout_err) pulses++;
            step();
            lat++;
        end
        check("to_latency", lat, TO + 2);
        for (int t = 0; t < 5; t++) begin
            if (timeout_err) pulses++;
            step();
        end
        check("to_pulse_count", pulses, 1);
        check("to_result", {bus.resp_valid, bus.resp_quotient, bus.resp_remainder, bus.resp_overflow},
              {4'b0001, 32'd0, 32'd0, 1'b1});
        bus.resp_ready[0] = 1'b1;
        step();
        bus.resp_ready[0] = 1'b0;
        stub_silent = 1'b0;
`else
        pulses = 0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
